pipeline_stage_execution_md: RTL

Execution stage feeding the memory stage.
- Computes ALU results and load/store addresses.
- Hosts a multi-cycle multiply/divide unit with HI/LO registers.
- Registers its outputs once per instruction.
- Stalls upstream while mul/div iterates, emitting bubbles downstream meanwhile.
- Downstream never stalls this stage.

---
 rtl/pipeline_stage_execution_md.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stage_execution_md.sv
// Execute stage: single-cycle ALU and address generation, plus an iterative
// mul/div unit with HI/LO that stalls upstream and sends bubbles downstream.
module pipeline_stage_execution_md #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_reg_write_en,
  input  logic [4:0]            in_reg_write_id,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  output logic                  stall_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic                  out_reg_write_en,
  output logic [4:0]            out_reg_write_id,
  output logic                  out_reg_data_ready,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [1:0]            dbg_state
);

  localparam int W     = DATA_WIDTH;
  localparam int MAXN  = (W > MUL_CYCLES) ? W : MUL_CYCLES;
  localparam int CNT_W = $clog2(MAXN + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic             signed_q, signed_d;
  logic [W-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

  logic             valid_q, valid_d;
  logic [W-1:0]     opc_q, opc_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sd_q, sd_d;
  logic             we_q, we_d;
  logic [4:0]       wid_q, wid_d;
  logic             rdr_q, rdr_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;

  logic [W-1:0]     op_b;
  logic [4:0]       shamt;
  logic [W-1:0]     alu_res;
  logic             is_muldiv, is_mul, is_signed_in, accept;
  logic [W-1:0]     a_mag, b_mag;

  assign op_b         = in_use_imm ? in_imm : in_b;
  assign shamt        = op_b[4:0];
  assign is_muldiv    = (in_op >= OP_MULT) && (in_op <= OP_DIVU);
  assign is_mul       = (in_op == OP_MULT) || (in_op == OP_MULTU);
  assign is_signed_in = (in_op == OP_MULT) || (in_op == OP_DIV);
  assign accept       = (state_q == IDLE) && in_valid && is_muldiv;
  assign a_mag        = (is_signed_in && in_a[W-1]) ? (-in_a) : in_a;
  assign b_mag        = (is_signed_in && op_b[W-1]) ? (-op_b) : op_b;

  // Stall handshake: while stall_out is high the upstream stage holds every
  // in_* signal stable and this stage ignores them; an instruction is consumed
  // at a rising edge only when stall_out is low in the cycle before it.
  assign stall_out = reset && (accept || ((state_q != IDLE) && (cnt_q != '0)));
  assign dbg_state = state_q;

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_a + op_b;
      OP_SUB:  alu_res = in_a - op_b;
      OP_AND:  alu_res = in_a & op_b;
      OP_OR:   alu_res = in_a | op_b;
      OP_XOR:  alu_res = in_a ^ op_b;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (in_a < op_b)};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
    if (in_mem_read || in_mem_write) alu_res = in_a + op_b;
  end

  // Multiply: the low 2W bits of the sign/zero-extended product are exact.
  logic [2*W-1:0] prod_u, prod_s;
  assign prod_u = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign prod_s = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [W:0]   rem_sh, trial;
  logic [W-1:0] rem_nx, quo_nx;
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[W]) begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b0};
    end
  end

  logic         q_neg, r_neg;
  logic [W-1:0] div_lo, div_hi;
  always_comb begin
    q_neg = signed_q && (a_q[W-1] ^ b_q[W-1]);
    r_neg = signed_q && a_q[W-1];
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      div_lo = q_neg ? (-quo_nx) : quo_nx;
      div_hi = r_neg ? (-rem_nx) : rem_nx;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    pc_d     = pc_q;
    signed_d = signed_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    valid_d  = 1'b0;
    we_d     = 1'b0;
    rdr_d    = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    opc_d    = in_pc;
    res_d    = alu_res;
    sd_d     = in_b;
    wid_d    = in_reg_write_id;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = is_mul ? MUL_BUSY : DIV_BUSY;
          cnt_d    = is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(W - 1);
          a_d      = in_a;
          b_d      = op_b;
          pc_d     = in_pc;
          signed_d = is_signed_in;
          rem_d    = '0;
          quo_d    = a_mag;
          dvs_d    = b_mag;
        end else if (in_valid) begin
          valid_d = 1'b1;
          we_d    = in_reg_write_en;
          rdr_d   = ~in_mem_read;
          mr_d    = in_mem_read;
          mw_d    = in_mem_write;
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        // The release cycle performs the last divide step, W steps in total.
        if (state_q == DIV_BUSY) begin
          rem_d = rem_nx;
          quo_d = quo_nx;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          valid_d = 1'b1;
          opc_d   = pc_q;
          res_d   = '0;
          sd_d    = b_q;
          if (state_q == MUL_BUSY) begin
            {hi_d, lo_d} = signed_q ? prod_s : prod_u;
          end else begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      valid_q  <= 1'b0;
      opc_q    <= '0;
      res_q    <= '0;
      sd_q     <= '0;
      we_q     <= 1'b0;
      wid_q    <= '0;
      rdr_q    <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pc_q     <= pc_d;
      signed_q <= signed_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      valid_q  <= valid_d;
      opc_q    <= opc_d;
      res_q    <= res_d;
      sd_q     <= sd_d;
      we_q     <= we_d;
      wid_q    <= wid_d;
      rdr_q    <= rdr_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
    end
  end

  assign out_valid          = valid_q;
  assign out_pc             = opc_q;
  assign out_result         = res_q;
  assign out_store_data     = sd_q;
  assign out_reg_write_en   = we_q;
  assign out_reg_write_id   = wid_q;
  assign out_reg_data_ready = rdr_q;
  assign out_mem_read       = mr_q;
  assign out_mem_write      = mw_q;

endmodule
